controle_vendas: RTL
====================

// Module: controle_vendas
// PURPOSE
//  Vending-machine control FSM. Sits directly upstream of display_segmentos and drives its
//  estado/codigo_produto/total inputs. Takes debounced buttons, code switches and coin pulses,
//  validates the product code, accumulates payment in quarters and releases the product.
// PARAMETERS
//  NUM_PRODUTOS     8      valid codes are 0..NUM_PRODUTOS-1
//  PRECO_BASE       2      price(code) = PRECO_BASE + code, in quarters; must keep max price <= 11
//  TIMEOUT_CICLOS   5000   idle cycles in estado 1/2 before abort to 0
//  LIBERA_CICLOS    100    cycles spent in estado 3
// PORTS
//  clk             in   1  system clock
//  reset           in   1  synchronous, active-high
//  botao_confirma  in   1  debounced level; acted on at rising edge only
//  botao_cancela   in   1  debounced level; acted on at rising edge only
//  chaves_codigo   in   4  product code switches
//  moeda           in   2  coin code, held >=1 cycle: 00 none, 01 R$0.25, 10 R$0.50, 11 R$1.00
//  estado          out  2  0 idle/error, 1 selection, 2 payment, 3 release
//  codigo_produto  out  4  code shown in estado 1, latched code afterwards
//  total           out  4  credit in quarters, 0..11 (bits[3:2] reais, bits[1:0] quarters)
//  libera_produto  out  1  one-cycle pulse on entry to estado 3
//  moeda_rejeitada out  1  one-cycle pulse when a coin is refused
//  troco           out  4  change in quarters, valid with libera_produto (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (any state): estado=0, codigo_produto=0, total=0, all pulses 0, troco=0, timer=0,
//    edge-detect registers loaded with current input levels (a held button does not fire).
//  - Edge detect: one registered sample per input; event = level & ~prev. moeda event = nonzero
//    code with previous sample 00.
//  - Outputs are registered; every effect appears on the cycle after the event edge.
//  - Priority when events coincide: cancela > confirma > moeda.
//  - estado 0: confirma -> 1; total cleared on every entry to 0; coins rejected.
//  - estado 1: codigo_produto follows chaves_codigo every cycle. confirma: code<NUM_PRODUTOS ->
//    latch code, go to 2; otherwise -> 0 (display shows "not found" from 1->0). cancela -> 0.
//    Coins rejected.
//  - estado 2: coin adds 1/2/4 quarters; if the sum would exceed 11, total is unchanged and
//    moeda_rejeitada pulses. confirma with total >= price -> 3; confirma with total < price
//    -> 0 (display shows "insufficient" from 2->0). cancela -> 0 (credit returned externally).
//  - estado 3: libera_produto high on the first cycle only. After LIBERA_CICLOS cycles -> 0.
//    All inputs ignored; coins rejected.
//  - Timeout: counter clears on any event, counts in estado 1/2, and at TIMEOUT_CICLOS-1
//    forces the same transition as cancela.
//  - Comparisons are unsigned in 4 bits; the price function is evaluated at 4 bits with no
//    wrap, guaranteed by the parameter constraint.
// CONFIGURATION
//  TROCO_EN defined: on entry to 3, troco = total - price, held until the next entry to 0.
//  TROCO_EN undefined: troco tied to 0 and the excess credit is kept by the machine; the
//    subtraction logic is not built.
// TESTING
//  1 reset mid-payment (estado 2, total=6) -> next cycle estado=0, total=0, no pulses.
//  2 confirma, code=9 (NUM_PRODUTOS=8), confirma -> estado 0->1->0; codigo_produto=9 seen in 1.
//  3 code=3 (price 5), coins 01,10 -> total 3; confirma -> estado 0, total 0 (insufficient).
//  4 code=3, coins 11,01 -> total 5; confirma -> estado 3, libera_produto one cycle,
//    troco=0; back to 0 after LIBERA_CICLOS.
//  5 total=9, coin 10 -> total 11; coin 01 -> total 11, moeda_rejeitada pulse;
//    TROCO_EN with code 0 -> troco=9.
//  6 cancela+confirma same cycle in estado 2 -> estado 0; no input for TIMEOUT_CICLOS in 1 -> 0.

Source files
------------

// File: rtl/controle_vendas_if.sv
// controle_vendas_if: button/switch/coin inputs and display/release outputs of the vending controller
interface controle_vendas_if;
  logic       botao_confirma;
  logic       botao_cancela;
  logic [3:0] chaves_codigo;
  logic [1:0] moeda;
  logic [1:0] estado;
  logic [3:0] codigo_produto;
  logic [3:0] total;
  logic       libera_produto;
  logic       moeda_rejeitada;
  logic [3:0] troco;
  modport master (
    output botao_confirma, botao_cancela, chaves_codigo, moeda,
    input  estado, codigo_produto, total, libera_produto, moeda_rejeitada, troco
  );
  modport slave (
    input  botao_confirma, botao_cancela, chaves_codigo, moeda,
    output estado, codigo_produto, total, libera_produto, moeda_rejeitada, troco
  );
endinterface

// File: rtl/controle_vendas.sv
// controle_vendas: vending FSM (clk, reset, bus.slave: buttons/code/coins in; estado/codigo/total/pulses/troco out); TROCO_EN enables change output
module controle_vendas #(
  parameter int NUM_PRODUTOS   = 8,
  parameter int PRECO_BASE     = 2,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int LIBERA_CICLOS  = 100
) (
  input logic              clk,
  input logic              reset,
  controle_vendas_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam int LW = $clog2(LIBERA_CICLOS + 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEL = 2'd1, S_PAG = 2'd2, S_LIB = 2'd3} state_t;
  state_t r_state, w_next;
  logic          r_conf_prev, r_canc_prev;
  logic [1:0]    r_moeda_prev;
  logic [3:0]    r_cod, r_total, r_troco, w_cod, w_total, w_troco, w_preco;
  logic          r_libera, r_rej, w_libera, w_rej;
  logic [TW-1:0] r_timer, w_timer;
  logic [LW-1:0] r_lib, w_lib;
  logic          w_conf, w_canc, w_moeda_ev, w_tout, w_abort, w_aceita, w_valido;
  logic [4:0]    w_soma;
  assign w_conf     = bus.botao_confirma & ~r_conf_prev;
  assign w_canc     = bus.botao_cancela & ~r_canc_prev;
  assign w_moeda_ev = (bus.moeda != 2'b00) && (r_moeda_prev == 2'b00);
  assign w_tout     = (r_state == S_SEL || r_state == S_PAG) && r_timer == TW'(TIMEOUT_CICLOS - 1);
  assign w_abort    = w_canc | w_tout;
  assign w_valido   = {1'b0, bus.chaves_codigo} < 5'(NUM_PRODUTOS);
  assign w_preco    = 4'(PRECO_BASE) + r_cod;
  assign w_soma     = {1'b0, r_total} + (bus.moeda == 2'b01 ? 5'd1 : bus.moeda == 2'b10 ? 5'd2 : 5'd4);
  // a coin is only taken in payment when no higher-priority event claims the cycle
  assign w_aceita   = w_moeda_ev && r_state == S_PAG && !w_abort && !w_conf && w_soma <= 5'd11;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = w_conf ? S_SEL : S_IDLE;
      S_SEL:  w_next = w_abort ? S_IDLE : w_conf ? (w_valido ? S_PAG : S_IDLE) : S_SEL;
      S_PAG:  w_next = w_abort ? S_IDLE : w_conf ? (r_total >= w_preco ? S_LIB : S_IDLE) : S_PAG;
      S_LIB:  w_next = r_lib == LW'(LIBERA_CICLOS - 1) ? S_IDLE : S_LIB;
      default: w_next = S_IDLE;
    endcase
    w_total  = w_next == S_IDLE ? 4'd0 : w_aceita ? w_soma[3:0] : r_total;
    w_cod    = (r_state == S_SEL || w_next == S_SEL) ? bus.chaves_codigo : r_cod;
    w_libera = w_next == S_LIB && r_state != S_LIB;
    w_rej    = w_moeda_ev && !w_aceita;
    w_lib    = (r_state == S_LIB && w_next == S_LIB) ? r_lib + 1'b1 : '0;
    w_timer  = (w_conf || w_canc || w_moeda_ev || (w_next != S_SEL && w_next != S_PAG)) ? '0 : r_timer + 1'b1;
`ifdef TROCO_EN
    w_troco  = w_next == S_IDLE ? 4'd0 : w_libera ? r_total - w_preco : r_troco;
`else
    w_troco  = 4'd0;
`endif
  end
  always_ff @(posedge clk) begin
    r_conf_prev  <= bus.botao_confirma;
    r_canc_prev  <= bus.botao_cancela;
    r_moeda_prev <= bus.moeda;
    if (reset) begin
      r_state  <= S_IDLE;
      r_cod    <= '0;
      r_total  <= '0;
      r_troco  <= '0;
      r_libera <= 1'b0;
      r_rej    <= 1'b0;
      r_timer  <= '0;
      r_lib    <= '0;
    end else begin
      r_state  <= w_next;
      r_cod    <= w_cod;
      r_total  <= w_total;
      r_troco  <= w_troco;
      r_libera <= w_libera;
      r_rej    <= w_rej;
      r_timer  <= w_timer;
      r_lib    <= w_lib;
    end
  end
  assign bus.estado          = r_state;
  assign bus.codigo_produto  = r_cod;
  assign bus.total           = r_total;
  assign bus.libera_produto  = r_libera;
  assign bus.moeda_rejeitada = r_rej;
  assign bus.troco           = r_troco;
endmodule
